// File: rtl/matmul_cfg_regs.sv
// APB register bank for the systolic matmul core: holds A/B/C base addresses and
// M/N/P dimensions, validates and launches a job, and tracks busy/done/err.
module matmul_cfg_regs #(
  parameter int                DATA_W  = 16,
  parameter logic [DATA_W-1:0] MAX_DIM = 16'd1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        paddr,
  input  logic              psel,
  input  logic              pwrite,
  input  logic [DATA_W-1:0] pwdata,
  output logic              pready,
  output logic [DATA_W-1:0] prdata,
  output logic              pslverr,
  output logic [DATA_W-1:0] a_addr,
  output logic [DATA_W-1:0] b_addr,
  output logic [DATA_W-1:0] c_addr,
  output logic [DATA_W-1:0] m,
  output logic [DATA_W-1:0] n,
  output logic [DATA_W-1:0] p,
  output logic              start,
  input  logic              core_done,
  output logic              done_apb
);

  typedef enum logic {
    APB_IDLE,
    APB_ACCESS
  } apb_state_t;

  typedef enum logic [1:0] {
    JOB_IDLE,
    JOB_RUN,
    JOB_DONE
  } job_state_t;

  localparam logic [2:0] ADDR_CTRL   = 3'd6;
  localparam logic [2:0] ADDR_STATUS = 3'd7;

  apb_state_t        apb_q, apb_next;
  job_state_t        job_q, job_next;
  logic              armed_q;
  logic [2:0]        addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cfg_q [6];
  logic              err_q, err_next;

  logic              take;
  logic              acc;
  logic              wr_en;
  logic              is_cfg;
  logic              running;
  logic              dims_ok;
  logic              launch_req;
  logic              clear_req;
  logic              launch_ok;
  logic              launch_bad;
  logic              cfg_reject;
  logic [DATA_W-1:0] status;
  logic [DATA_W-1:0] rd_val;

  function automatic logic dim_legal(input logic [DATA_W-1:0] v);
    return (v != '0) && (v <= MAX_DIM);
  endfunction

  // A psel held high across pready must not start a second transfer, so a new
  // transfer is only accepted once psel has been seen low.
  assign take = (apb_q == APB_IDLE) && psel && armed_q;

  always_comb begin
    // NOTE: default first so every path assigns apb_next and no latch is inferred.
    apb_next = apb_q;
    unique case (apb_q)
      APB_IDLE:   if (take) apb_next = APB_ACCESS;
      APB_ACCESS: apb_next = APB_IDLE;
      default:    apb_next = APB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      apb_q   <= APB_IDLE;
      armed_q <= 1'b1;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      apb_q <= apb_next;
      if (!psel)     armed_q <= 1'b1;
      else if (take) armed_q <= 1'b0;
      if (take) begin
        addr_q  <= paddr;
        write_q <= pwrite;
        wdata_q <= pwdata;
      end
    end
  end

  assign acc        = (apb_q == APB_ACCESS);
  assign wr_en      = acc && write_q;
  assign is_cfg     = (addr_q < ADDR_CTRL);
  assign running    = (job_q == JOB_RUN);
  assign dims_ok    = dim_legal(cfg_q[3]) && dim_legal(cfg_q[4]) && dim_legal(cfg_q[5]);
  assign launch_req = wr_en && (addr_q == ADDR_CTRL) && wdata_q[0];
  assign clear_req  = wr_en && (addr_q == ADDR_CTRL) && wdata_q[1];
  assign launch_ok  = launch_req && !running && dims_ok;
  assign launch_bad = launch_req && (running || !dims_ok);
  assign cfg_reject = wr_en && is_cfg && running;

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the config array is architectural state read by software, so it is reset too.
      for (int i = 0; i < 6; i++) cfg_q[i] <= '0;
    end else if (wr_en && is_cfg && !running) begin
      for (int i = 0; i < 6; i++)
        if (addr_q == 3'(i)) cfg_q[i] <= wdata_q;
    end
  end

  // A successful launch wins over a clear in the same CTRL write; an illegal
  // launch still records err after any clear.
  always_comb begin
    job_next = job_q;
    err_next = err_q;
    unique case (job_q)
      JOB_IDLE, JOB_DONE: begin
        if (launch_ok) begin
          job_next = JOB_RUN;
          err_next = 1'b0;
        end else begin
          if (clear_req) begin
            job_next = JOB_IDLE;
            err_next = 1'b0;
          end
          if (launch_bad) err_next = 1'b1;
        end
      end
      JOB_RUN: if (core_done) job_next = JOB_DONE;
      default: job_next = JOB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      job_q <= JOB_IDLE;
      err_q <= 1'b0;
    end else begin
      job_q <= job_next;
      err_q <= err_next;
    end
  end

  assign status = {{(DATA_W-3){1'b0}}, err_q, (job_q == JOB_DONE), running};

  always_comb begin
    rd_val = '0;
    unique case (addr_q)
      3'd0:        rd_val = cfg_q[0];
      3'd1:        rd_val = cfg_q[1];
      3'd2:        rd_val = cfg_q[2];
      3'd3:        rd_val = cfg_q[3];
      3'd4:        rd_val = cfg_q[4];
      3'd5:        rd_val = cfg_q[5];
      ADDR_STATUS: rd_val = status;
      default:     rd_val = '0;
    endcase
  end

  assign pready   = acc;
  assign prdata   = (acc && !write_q) ? rd_val : '0;
  assign pslverr  = launch_bad || cfg_reject;
  assign start    = launch_ok;
  assign done_apb = (job_q == JOB_DONE);

  assign a_addr = cfg_q[0];
  assign b_addr = cfg_q[1];
  assign c_addr = cfg_q[2];
  assign m      = cfg_q[3];
  assign n      = cfg_q[4];
  assign p      = cfg_q[5];

endmodule

// File: tb/tb_matmul_cfg_regs.sv
// Self-checking bench for matmul_cfg_regs: directed vector table, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_matmul_cfg_regs;

  localparam int          DW   = 16;
  localparam logic [15:0] MAXD = 16'd1024;

  logic          clk;
  logic          reset;
  logic [2:0]    paddr;
  logic          psel;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic          pready;
  logic [DW-1:0] prdata;
  logic          pslverr;
  logic [DW-1:0] a_addr, b_addr, c_addr, m, n, p;
  logic          start;
  logic          core_done;
  logic          done_apb;

  matmul_cfg_regs #(.DATA_W(DW), .MAX_DIM(MAXD)) dut (
    .clk(clk), .reset(reset), .paddr(paddr), .psel(psel), .pwrite(pwrite),
    .pwdata(pwdata), .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .a_addr(a_addr), .b_addr(b_addr), .c_addr(c_addr), .m(m), .n(n), .p(p),
    .start(start), .core_done(core_done), .done_apb(done_apb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level model: register contents plus software-visible job flags.
  logic [15:0] mreg [6];
  bit m_busy, m_done, m_err;

  task automatic model_reset();
    for (int i = 0; i < 6; i++) mreg[i] = '0;
    m_busy = 0; m_done = 0; m_err = 0;
  endtask

  task automatic model_xfer(input logic [2:0] a, input bit wr, input logic [15:0] d,
                            output logic [15:0] erd, output bit eerr, output int estart);
    bit legal;
    erd = '0; eerr = 0; estart = 0;
    legal = 1;
    for (int i = 3; i < 6; i++) if (mreg[i] == 0 || mreg[i] > MAXD) legal = 0;
    if (!wr) begin
      if (a < 6)       erd = mreg[a];
      else if (a == 7) erd = {13'b0, m_err, m_done, m_busy};
    end else if (a < 6) begin
      if (m_busy) eerr = 1;
      else        mreg[a] = d;
    end else if (a == 6) begin
      if (m_busy) begin
        if (d[0]) eerr = 1;
      end else if (d[0] && legal) begin
        estart = 1; m_busy = 1; m_done = 0; m_err = 0;
      end else begin
        if (d[1]) begin m_done = 0; m_err = 0; end
        if (d[0]) begin eerr = 1; m_err = 1; end
      end
    end
  endtask

  task automatic model_core_done();
    if (m_busy) begin m_busy = 0; m_done = 1; end
  endtask

  // One APB transfer: psel held for 'hold' cycles; optionally pulse core_done
  // so it is sampled on the same edge that completes the transfer.
  task automatic apb_xfer(input logic [2:0] a, input bit wr, input logic [15:0] d,
                          input int hold, input bit cd,
                          output logic [15:0] rdata, output bit err,
                          output int nready, output int nstart, output int lat);
    rdata = '0; err = 0; nready = 0; nstart = 0; lat = -1;
    @(negedge clk);
    psel = 1; paddr = a; pwrite = wr; pwdata = d;
    for (int i = 0; i < hold + 2; i++) begin
      @(negedge clk);
      core_done = 0;
      if (pready) begin
        nready++;
        if (lat < 0) lat = i;
        rdata = prdata; err = pslverr;
        core_done = cd;
      end
      if (start) nstart++;
      if (i == hold - 1) psel = 0;
    end
    core_done = 0;
  endtask

  task automatic pulse_core_done();
    @(negedge clk); core_done = 1;
    @(negedge clk); core_done = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1; psel = 0; core_done = 0;
    @(negedge clk); @(negedge clk); reset = 0;
    model_reset();
  endtask

  task automatic check_outputs_model(input string tag);
    check({tag, " a_addr"}, a_addr, mreg[0]);
    check({tag, " b_addr"}, b_addr, mreg[1]);
    check({tag, " c_addr"}, c_addr, mreg[2]);
    check({tag, " m"}, m, mreg[3]);
    check({tag, " n"}, n, mreg[4]);
    check({tag, " p"}, p, mreg[5]);
    check({tag, " done_apb"}, done_apb, m_done);
  endtask

  typedef struct {
    bit          cd_before;
    logic [2:0]  addr;
    bit          wr;
    logic [15:0] data;
    logic [15:0] exp_rdata;
    bit          exp_err;
    int          exp_start;
    bit          exp_done_apb;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit cd, input logic [2:0] a, input bit wr, input logic [15:0] d,
                     input logic [15:0] erd, input bit eerr, input int est, input bit edone);
    vecs.push_back('{cd, a, wr, d, erd, eerr, est, edone});
  endtask

  function automatic logic [15:0] rand_dim();
    case ($urandom_range(0, 7))
      0:       return 16'd0;
      1:       return 16'd1025;
      2:       return 16'd1024;
      default: return 16'($urandom_range(1, 64));
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] rd, erd;
    bit          err, eerr;
    int          nr, ns, lat, est;

    reset = 1; psel = 0; paddr = '0; pwrite = 0; pwdata = '0; core_done = 0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 0;

    @(negedge clk);
    check("reset pready", pready, 0);
    check("reset prdata", prdata, 0);
    check("reset pslverr", pslverr, 0);
    check("reset start", start, 0);
    check_outputs_model("reset");

    // Directed table
    add(0, 0, 1, 16'h0000, 0, 0, 0, 0);
    add(0, 1, 1, 16'h0100, 0, 0, 0, 0);
    add(0, 2, 1, 16'h0200, 0, 0, 0, 0);
    add(0, 3, 1, 16'd32,   0, 0, 0, 0);
    add(0, 4, 1, 16'd32,   0, 0, 0, 0);
    add(0, 5, 1, 16'd32,   0, 0, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 0, 0, 0);
    add(0, 1, 0, 0, 16'h0100, 0, 0, 0);
    add(0, 2, 0, 0, 16'h0200, 0, 0, 0);
    add(0, 3, 0, 0, 16'd32,   0, 0, 0);
    add(0, 4, 0, 0, 16'd32,   0, 0, 0);
    add(0, 5, 0, 0, 16'd32,   0, 0, 0);
    add(0, 6, 1, 16'h0001, 0, 0, 1, 0);
    add(0, 7, 0, 0, 16'h0001, 0, 0, 0);
    add(0, 3, 1, 16'd8,    0, 1, 0, 0);
    add(0, 3, 0, 0, 16'd32,   0, 0, 0);
    add(0, 6, 1, 16'h0001, 0, 1, 0, 0);
    add(0, 7, 0, 0, 16'h0001, 0, 0, 0);
    add(1, 7, 0, 0, 16'h0002, 0, 0, 1);
    add(0, 6, 1, 16'h0002, 0, 0, 0, 0);
    add(0, 7, 0, 0, 16'h0000, 0, 0, 0);
    add(0, 4, 1, 16'd0,    0, 0, 0, 0);
    add(0, 6, 1, 16'h0001, 0, 1, 0, 0);
    add(0, 7, 0, 0, 16'h0004, 0, 0, 0);
    add(0, 4, 1, 16'd32,   0, 0, 0, 0);
    add(0, 5, 1, 16'd1025, 0, 0, 0, 0);
    add(0, 6, 1, 16'h0001, 0, 1, 0, 0);
    add(0, 7, 0, 0, 16'h0004, 0, 0, 0);
    add(0, 6, 1, 16'h0002, 0, 0, 0, 0);
    add(0, 7, 0, 0, 16'h0000, 0, 0, 0);
    add(0, 5, 1, 16'd1024, 0, 0, 0, 0);
    add(0, 5, 0, 0, 16'd1024, 0, 0, 0);
    add(0, 5, 1, 16'd32,   0, 0, 0, 0);

    foreach (vecs[i]) begin
      if (vecs[i].cd_before) pulse_core_done();
      apb_xfer(vecs[i].addr, vecs[i].wr, vecs[i].data, 2, 0, rd, err, nr, ns, lat);
      check($sformatf("vec%0d pready count", i), nr, 1);
      check($sformatf("vec%0d latency", i), lat, 0);
      check($sformatf("vec%0d pslverr", i), err, vecs[i].exp_err);
      check($sformatf("vec%0d start", i), ns, vecs[i].exp_start);
      check($sformatf("vec%0d done_apb", i), done_apb, vecs[i].exp_done_apb);
      if (!vecs[i].wr) check($sformatf("vec%0d prdata", i), rd, vecs[i].exp_rdata);
    end
    check("table a_addr", a_addr, 16'h0000);
    check("table b_addr", b_addr, 16'h0100);
    check("table c_addr", c_addr, 16'h0200);
    check("table m", m, 16'd32);
    check("table n", n, 16'd32);
    check("table p", p, 16'd32);

    // psel held for 5 cycles is one transfer
    apb_xfer(0, 1, 16'hBEEF, 5, 0, rd, err, nr, ns, lat);
    check("hold5 pready count", nr, 1);
    check("hold5 a_addr", a_addr, 16'hBEEF);

    // core_done while idle is ignored
    pulse_core_done();
    apb_xfer(7, 0, 0, 1, 0, rd, err, nr, ns, lat);
    check("idle core_done status", rd, 16'h0000);
    check("idle core_done done_apb", done_apb, 0);

    // core_done coincident with a rejected write during RUN
    apb_xfer(6, 1, 16'h0001, 1, 0, rd, err, nr, ns, lat);
    check("cd+wr launch start", ns, 1);
    apb_xfer(3, 1, 16'd8, 1, 1, rd, err, nr, ns, lat);
    check("cd+wr pslverr", err, 1);
    check("cd+wr m kept", m, 16'd32);
    check("cd+wr done_apb", done_apb, 1);
    apb_xfer(7, 0, 0, 1, 0, rd, err, nr, ns, lat);
    check("cd+wr status", rd, 16'h0002);

    // Randomized run against the model
    do_reset();
    for (int it = 0; it < 300; it++) begin
      int          kind;
      logic [2:0]  a;
      bit          wr, cd;
      logic [15:0] d;
      int          hold;
      kind = $urandom_range(0, 9);
      hold = $urandom_range(1, 3);
      cd = 0; wr = 1; a = 0; d = 16'($urandom);
      if (kind == 7) begin
        pulse_core_done();
        model_core_done();
        check($sformatf("rnd%0d core_done done_apb", it), done_apb, m_done);
      end else begin
        case (kind)
          4, 5: begin a = 3'($urandom_range(0, 7)); wr = 0; end
          6: begin
            a = 6;
            d[0] = ($urandom_range(0, 3) != 0);
            d[1] = 1'($urandom_range(0, 1));
          end
          8: a = 7;
          default: begin
            a = 3'($urandom_range(0, 5));
            if (a >= 3) d = rand_dim();
            cd = (kind == 9);
          end
        endcase
        model_xfer(a, wr, d, erd, eerr, est);
        if (cd) model_core_done();
        apb_xfer(a, wr, d, hold, cd, rd, err, nr, ns, lat);
        check($sformatf("rnd%0d pready count", it), nr, 1);
        check($sformatf("rnd%0d pslverr", it), err, eerr);
        check($sformatf("rnd%0d start", it), ns, est);
        if (!wr) check($sformatf("rnd%0d prdata a=%0d", it, a), rd, erd);
        check_outputs_model($sformatf("rnd%0d", it));
      end
    end

    // Reset during RUN, then a late core_done
    do_reset();
    for (int i = 3; i < 6; i++) apb_xfer(3'(i), 1, 16'd32, 1, 0, rd, err, nr, ns, lat);
    apb_xfer(0, 1, 16'h1234, 1, 0, rd, err, nr, ns, lat);
    apb_xfer(6, 1, 16'h0001, 1, 0, rd, err, nr, ns, lat);
    check("rst-run launch start", ns, 1);
    @(negedge clk); reset = 1;
    @(negedge clk);
    check("rst-run pready", pready, 0);
    check("rst-run prdata", prdata, 0);
    check("rst-run pslverr", pslverr, 0);
    check("rst-run start", start, 0);
    model_reset();
    check_outputs_model("rst-run");
    reset = 0;
    pulse_core_done();
    check("rst-run late core_done", done_apb, 0);
    apb_xfer(7, 0, 0, 1, 0, rd, err, nr, ns, lat);
    check("rst-run status", rd, 16'h0000);

    // Reset during ACCESS: the transfer is dropped
    @(negedge clk); psel = 1; paddr = 0; pwrite = 1; pwdata = 16'h5555;
    @(negedge clk);
    check("rst-acc pready before", pready, 1);
    reset = 1; psel = 0;
    @(negedge clk);
    check("rst-acc pready", pready, 0);
    check("rst-acc start", start, 0);
    check("rst-acc a_addr", a_addr, 16'h0000);
    reset = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
